dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the five-stage pipeline. The MEM stage starts each load or store with a request. This block accepts the request, waits a fixed number of cycles, and then performs the word access. It pulses an acknowledge and drives a stall line so the pipeline registers hold while an access is outstanding. It replaces the single-cycle combinational data memory behind the EX/MEM register.

---
 rtl/dmem_responder_if.sv | 15 +
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM pipeline stage and the data-memory responder.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic        stall;

  modport master (output req, we, addr, wdata, input rdata, ack, err, busy, stall);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy, stall);
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory: accepts a request, waits LATENCY cycles,
// performs the access and pulses ack; stall holds the pipeline while req is unanswered.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int         DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem [DEPTH];

  logic                accept_s;
  logic                access_s;
  logic                acc_we_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [31:0]         acc_wdata_s;
  logic                misal_s;
  logic [ADDR_W-3:0]   idx_s;
  logic                unused_s;

  // Address bits above the decoded window are ignored (addresses wrap).
  assign unused_s = ^bus.addr[31:ADDR_W];

  // Access operands: live bus inputs for a zero-latency access, latched copy otherwise.
  always_comb begin
    accept_s = (state_q == S_IDLE) && bus.req;
    if (state_q == S_IDLE) begin
      acc_we_s    = bus.we;
      acc_addr_s  = bus.addr[ADDR_W-1:0];
      acc_wdata_s = bus.wdata;
    end else begin
      acc_we_s    = we_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
    access_s = (accept_s && (LAT_C == 4'd0)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
    misal_s  = (acc_addr_s[1:0] != 2'b00);
    idx_s    = acc_addr_s[ADDR_W-1:2];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; req is not sampled in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cnt_d = LAT_C;
          if (LAT_C == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    bus.ack   = (state_q == S_DONE);
    bus.busy  = (state_q != S_IDLE);
    bus.err   = err_q;
    bus.rdata = rdata_q;
    bus.stall = bus.req && !(state_q == S_DONE);
  end

  // Request latch plus load/error result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr[ADDR_W-1:0];
        wdata_q <= bus.wdata;
      end
      if (access_s) begin
        err_q <= misal_s;
        if (misal_s) begin
          rdata_q <= 32'd0;
        end else if (!acc_we_s) begin
          rdata_q <= mem[idx_s];
        end
      end else begin
        err_q <= 1'b0;
      end
    end
  end

  // Storage array is deliberately not reset; a store during reset never commits.
  always_ff @(posedge clk) begin
    if (access_s && acc_we_s && !misal_s && !rst) begin
      mem[idx_s] <= acc_wdata_s;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: LATENCY=2 and LATENCY=0 instances against a word-array reference model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if if2();
  dmem_responder_if if0();

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  int n_chk  = 0;
  int n_fail = 0;

  // Index 0 models the LATENCY=2 instance, index 1 the LATENCY=0 instance.
  logic [31:0] mem_m   [2][256];
  logic [31:0] rdata_m [2];

  logic        ack_w   [2];
  logic        err_w   [2];
  logic        busy_w  [2];
  logic        stall_w [2];
  logic [31:0] rdata_w [2];

  assign ack_w[0]   = if2.ack;
  assign err_w[0]   = if2.err;
  assign busy_w[0]  = if2.busy;
  assign stall_w[0] = if2.stall;
  assign rdata_w[0] = if2.rdata;
  assign ack_w[1]   = if0.ack;
  assign err_w[1]   = if0.err;
  assign busy_w[1]  = if0.busy;
  assign stall_w[1] = if0.stall;
  assign rdata_w[1] = if0.rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (s == 0) begin
      if2.req = r; if2.we = w; if2.addr = a; if2.wdata = d;
    end else begin
      if0.req = r; if0.we = w; if0.addr = a; if0.wdata = d;
    end
  endtask

  task automatic model_access(input int s, input logic w, input logic [31:0] a,
                              input logic [31:0] d, output logic e);
    e = (a[1:0] != 2'b00);
    if (e) rdata_m[s] = 32'h0;
    else if (w) mem_m[s][a[9:2]] = d;
    else rdata_m[s] = mem_m[s][a[9:2]];
  endtask

  // One complete transaction starting at a falling edge; checks every cycle through the idle one after ack.
  task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    int   lat;
    logic e_err;
    lat = (s == 0) ? 2 : 0;
    drive(s, 1'b1, w, a, d);
    #1;
    chk({tag, ".stall_req"}, 32'(stall_w[s]), 32'd1);
    chk({tag, ".busy_idle"}, 32'(busy_w[s]), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk({tag, ".ack_wait"}, 32'(ack_w[s]), 32'd0);
      chk({tag, ".busy_wait"}, 32'(busy_w[s]), 32'd1);
      if (i == 1) drive(s, 1'b1, ~w, 32'h20, 32'h0);
      else drive(s, 1'b1, ~w, $urandom, $urandom);
    end
    @(negedge clk);
    model_access(s, w, a, d, e_err);
    chk({tag, ".ack"}, 32'(ack_w[s]), 32'd1);
    chk({tag, ".err"}, 32'(err_w[s]), 32'(e_err));
    chk({tag, ".busy_ack"}, 32'(busy_w[s]), 32'd1);
    chk({tag, ".stall_ack"}, 32'(stall_w[s]), 32'd0);
    chk({tag, ".rdata"}, rdata_w[s], rdata_m[s]);
    drive(s, 1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom);
    @(negedge clk);
    chk({tag, ".ack_after"}, 32'(ack_w[s]), 32'd0);
    chk({tag, ".busy_after"}, 32'(busy_w[s]), 32'd0);
    chk({tag, ".err_after"}, 32'(err_w[s]), 32'd0);
    chk({tag, ".rdata_hold"}, rdata_w[s], rdata_m[s]);
  endtask

  initial begin
    logic [31:0] a;
    logic        e;
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    rdata_m[0] = 32'h0;
    rdata_m[1] = 32'h0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst.ack", 32'(ack_w[s]), 32'd0);
      chk("rst.err", 32'(err_w[s]), 32'd0);
      chk("rst.busy", 32'(busy_w[s]), 32'd0);
      chk("rst.rdata", rdata_w[s], 32'h0);
      chk("rst.stall", 32'(stall_w[s]), 32'd1);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst.stall_low", 32'(stall_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, "st10");
    access(0, 1'b0, 32'h10, 32'h0, "ld10");
    access(0, 1'b0, 32'h13, 32'h0, "misal_ld");
    access(0, 1'b0, 32'h10, 32'h0, "ld10_again");
    access(0, 1'b1, 32'h404, 32'h12345678, "wrap_st");
    access(0, 1'b0, 32'h4, 32'h0, "wrap_ld");
    access(0, 1'b0, 32'h20, 32'h0, "ld20_untouched");
    access(0, 1'b1, 32'h11, 32'h55555555, "misal_st");
    access(0, 1'b0, 32'h10, 32'h0, "ld10_after_misal_st");

    // Store aborted by reset in its second wait cycle.
    drive(0, 1'b1, 1'b1, 32'h40, 32'hAAAA5555);
    @(negedge clk);
    chk("abort.busy", 32'(busy_w[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rdata_m[0] = 32'h0;
    rdata_m[1] = 32'h0;
    chk("abort.busy_rst", 32'(busy_w[0]), 32'd0);
    chk("abort.ack_rst", 32'(ack_w[0]), 32'd0);
    chk("abort.rdata_rst", rdata_w[0], 32'h0);
    chk("abort.stall_rst", 32'(stall_w[0]), 32'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("abort.no_ack", 32'(ack_w[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    access(0, 1'b0, 32'h40, 32'h0, "ld40_aborted");
    access(0, 1'b1, 32'h40, 32'h1, "st40");
    access(0, 1'b0, 32'h40, 32'h0, "ld40");
    access(0, 1'b0, 32'h80, 32'h0, "ld80_never");

    access(1, 1'b1, 32'h8, 32'hCAFEF00D, "l0_st");
    access(1, 1'b0, 32'h8, 32'h0, "l0_ld");

    // Zero latency with req held: acks one cycle apart from an idle cycle.
    drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        model_access(1, 1'b0, 32'h8, 32'h0, e);
        chk("held.ack", 32'(ack_w[1]), 32'd1);
        chk("held.stall_ack", 32'(stall_w[1]), 32'd0);
        chk("held.rdata", rdata_w[1], rdata_m[1]);
      end else begin
        chk("held.idle", 32'(ack_w[1]), 32'd0);
        chk("held.stall_idle", 32'(stall_w[1]), 32'd1);
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("held.ack_end", 32'(ack_w[1]), 32'd0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a[9:2] = 8'(8'h30 + $urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(int'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, a, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
